// File: rtl/sequential_divider_4_bit.sv
// sequential_divider_4_bit
//   Multi-cycle restoring divider: unsigned quotient and remainder of a
//   WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
//   A start/busy/done handshake launches a division and reports completion.
//   Results are registered and held until the next accepted start.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   start        request a division, sampled only in IDLE
//   dividend     unsigned dividend, captured on an accepted start
//   divisor      unsigned divisor, captured on an accepted start
//   quotient     registered unsigned quotient
//   remainder    registered unsigned remainder
//   busy         high while a division is in progress (DIVIDE and DONE)
//   done         one-cycle pulse, results valid
//   div_by_zero  registered flag, set when the captured divisor was 0
module sequential_divider_4_bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    // Counter wide enough to hold the last iteration index WIDTH-1.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] q_r;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_r;        // captured divisor
    logic [WIDTH-1:0] r_r;        // partial remainder
    logic [CW-1:0]    cnt_r;      // iteration counter

    logic [WIDTH:0]   t_s;        // trial value {R, next dividend bit}
    logic             ge_s;       // trial value >= divisor
    logic [WIDTH-1:0] diff_s;     // trial value minus divisor
    logic [WIDTH-1:0] r_next_s;
    logic [WIDTH-1:0] q_next_s;

    // One restoring-division step: shift in the next dividend bit and
    // subtract the divisor when it fits.
    always_comb begin
        t_s  = {r_r, q_r[WIDTH-1]};
        ge_s = (t_s >= {1'b0, d_r});
        // When the subtraction is kept the result is below the divisor, so
        // the low WIDTH bits of the difference are exact; the (WIDTH+1)-bit
        // trial value only needs its carry bit for the comparison.
        diff_s = t_s[WIDTH-1:0] - d_r;
        if (ge_s) begin
            r_next_s = diff_s;
            q_next_s = {q_r[WIDTH-2:0], 1'b1};
        end else begin
            r_next_s = t_s[WIDTH-1:0];
            q_next_s = {q_r[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            q_r         <= '0;
            d_r         <= '0;
            r_r         <= '0;
            cnt_r       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        q_r   <= dividend;
                        d_r   <= divisor;
                        r_r   <= '0;
                        cnt_r <= '0;
                        busy  <= 1'b1;
                        if (divisor == {WIDTH{1'b0}}) begin
                            // Divide by zero completes on the capture edge.
                            quotient    <= {WIDTH{1'b1}};
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            done        <= 1'b0;
                            state_r     <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    r_r   <= r_next_s;
                    q_r   <= q_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_ITER) begin
                        quotient  <= q_next_s;
                        remainder <= r_next_s;
                        done      <= 1'b1;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_divider_4_bit.sv
// Scoreboard bench for sequential_divider_4_bit: the driver pushes the
// expected result of every accepted division, the monitor pops and compares
// whenever done is seen, and checks that results hold between completions.
module tb_sequential_divider_4_bit;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        int         cap;    // cycle count right after the capture edge
        int         lat;    // edges from capture edge to done being visible
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    exp_t       sb[$];
    int         cyc = 0;
    logic       rst_d = 1'b1;
    int         errors = 0;
    int         checks = 0;
    logic [3:0] hold_q = 4'd0;
    logic [3:0] hold_r = 4'd0;
    logic       hold_dbz = 1'b0;
    logic       prev_done = 1'b0;

    sequential_divider_4_bit #(.WIDTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and registered copy of rst, both stable at the negedge.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: compares on every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_d) begin
                chk("reset_quotient", quotient, 0);
                chk("reset_remainder", remainder, 0);
                chk("reset_busy", busy, 0);
                chk("reset_done", done, 0);
                chk("reset_dbz", div_by_zero, 0);
                sb.delete();
                hold_q    = 4'd0;
                hold_r    = 4'd0;
                hold_dbz  = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (done) begin
                    chk("done_pulse_single", prev_done, 0);
                    chk("busy_with_done", busy, 1);
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("quotient", quotient, e.q);
                        chk("remainder", remainder, e.r);
                        chk("div_by_zero", div_by_zero, e.dbz);
                        chk("latency", cyc - e.cap, e.lat);
                        hold_q   = e.q;
                        hold_r   = e.r;
                        hold_dbz = e.dbz;
                    end
                end else begin
                    chk("hold_quotient", quotient, hold_q);
                    chk("hold_remainder", remainder, hold_r);
                    chk("hold_dbz", div_by_zero, hold_dbz);
                end
                prev_done = done;
            end
        end
    end

    // Wait for IDLE, issue one division and record what it must produce.
    task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er,
                          input logic edz);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 1, 0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.q = eq; e.r = er; e.dbz = edz; e.cap = cyc; e.lat = edz ? 0 : 4;
        sb.push_back(e);
        if (!edz) hold_dbz = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        exp_t e;
        int   c0;
        rst = 1'b1; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, expected values computed by hand.
        do_div(4'd13, 4'd3,  4'd4,  4'd1, 1'b0);
        drain();
        repeat (3) @(negedge clk);       // results must hold while idle
        do_div(4'd15, 4'd1,  4'd15, 4'd0, 1'b0);
        do_div(4'd0,  4'd5,  4'd0,  4'd0, 1'b0);
        do_div(4'd2,  4'd9,  4'd0,  4'd2, 1'b0);
        do_div(4'd15, 4'd15, 4'd1,  4'd0, 1'b0);
        do_div(4'd7,  4'd0,  4'hF,  4'd7, 1'b1);
        do_div(4'd8,  4'd2,  4'd4,  4'd0, 1'b0);
        drain();

        // start held high; operands change after capture.
        @(negedge clk);
        dividend = 4'd14; divisor = 4'd4; start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        e.q = 4'd3; e.r = 4'd2; e.dbz = 1'b0; e.cap = c0; e.lat = 4;
        sb.push_back(e);
        @(negedge clk);
        dividend = 4'd9; divisor = 4'd2;
        // Four iterations, one edge in DONE, one back to IDLE, then capture.
        e.q = 4'd4; e.r = 4'd1; e.dbz = 1'b0; e.cap = c0 + 6; e.lat = 4;
        sb.push_back(e);
        repeat (6) @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // Reset two cycles into 11/2 aborts it without a done pulse.
        @(negedge clk);
        dividend = 4'd11; divisor = 4'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.q = 4'd5; e.r = 4'd1; e.dbz = 1'b0; e.cap = cyc; e.lat = 4;
        sb.push_back(e);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_queue_cleared", sb.size(), 0);
        do_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0);
        drain();

        // Sweep of every operand pair.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    do_div(4'(a), 4'd0, 4'hF, 4'(a), 1'b1);
                else
                    do_div(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0);
            end
        end
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
